// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame geometry and the tx/rx state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and pulses tick on the last count.
// clr realigns the count to zero so bit timing starts at byte acceptance.
module uart_baud_gen #(
    parameter int unsigned BIT_CYCLES = 10416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, idle-high line; one frame per accepted byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int unsigned IDX_W      = $clog2(FRAME_DATA_BITS);

    uart_state_e                state, state_next;
    logic [FRAME_DATA_BITS-1:0] shift, shift_next;
    logic [IDX_W-1:0]           bit_idx, bit_idx_next;
    logic                       txd_next;
    logic                       handshake;
    logic                       tick;
`ifdef UART_TX_PARITY_EN
    logic                       parity_bit, parity_next;
`endif

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = ~tx_ready;
    assign handshake = tx_valid && tx_ready;

    uart_baud_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (handshake),
        .tick  (tick)
    );

    // State and datapath registers; TxD lags state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            TxD        <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_idx    <= bit_idx_next;
            TxD        <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        txd_next     = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_bit;
`endif

        case (state)
            IDLE: begin
                txd_next = IDLE_LEVEL;
                if (handshake) begin
                    state_next   = START;
                    shift_next   = tx_data;
                    bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^tx_data;
`endif
                end
            end
            START: begin
                txd_next = START_LEVEL;
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                txd_next = shift[0];
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_idx == IDX_W'(FRAME_DATA_BITS - 1)) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_next = parity_bit;
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                txd_next = STOP_LEVEL;
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_CYCLES=10; frame vectors are hand-written {stop,[parity],data,start}.
// Define UART_TX_PARITY_EN for the 8E1 build.
module tb_uart_tx;

    localparam int unsigned BC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
    localparam logic [10:0] F61 = {1'b1, 1'b1, 8'h61, 1'b0};
    localparam logic [10:0] F00 = {1'b1, 1'b0, 8'h00, 1'b0};
    localparam logic [10:0] FFF = {1'b1, 1'b0, 8'hFF, 1'b0};
    localparam logic [10:0] FA5 = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    localparam int unsigned NB = 10;
    localparam logic [10:0] F61 = {1'b0, 1'b1, 8'h61, 1'b0};
    localparam logic [10:0] F00 = {1'b0, 1'b1, 8'h00, 1'b0};
    localparam logic [10:0] FFF = {1'b0, 1'b1, 8'hFF, 1'b0};
    localparam logic [10:0] FA5 = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TxD;
    logic       tx_busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx #(
        .CLK_FREQ  (40),
        .BAUD_RATE (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .TxD      (TxD),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the handshake edge; walks the whole frame and ends #1 after the edge that ends STOP.
    task automatic run_frame(input string tag, input logic [10:0] exp, input bit disturb);
        int bad;
        int n;
        check({tag, "_lat"}, 32'(TxD), 32'd1);
        check({tag, "_rdy0"}, 32'(tx_ready), 32'd0);
        for (int b = 0; b < int'(NB); b++) begin
            bad = 0;
            for (int c = 0; c < int'(BC); c++) begin
                tick();
                n = b * int'(BC) + c + 1;
                if (disturb) begin
                    if (n == 30) begin
                        tx_valid = 1'b1;
                        tx_data  = 8'h55;
                    end
                    if (n == 31) tx_valid = 1'b0;
                    if (n == 50) tx_data = 8'hAA;
                end
                if (TxD !== exp[b]) bad++;
                if (!(b == int'(NB) - 1 && c == int'(BC) - 1)) begin
                    if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bad++;
                end
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(bad), 32'd0);
        end
        check({tag, "_rdy1"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy0"}, 32'(tx_busy), 32'd0);
        check({tag, "_idle"}, 32'(TxD), 32'd1);
    endtask

    task automatic handshake(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick();
        tick();
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        #2 rst_n = 1'b1;

        // Idle with no valid
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (TxD !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Single 0x61 frame
        handshake(8'h61);
        tx_valid = 1'b0;
        run_frame("f61", F61, 1'b0);

        // Valid held: 0x00 then 0xFF back to back
        handshake(8'h00);
        tx_data = 8'hFF;
        run_frame("f00", F00, 1'b0);
        tick();
        tx_valid = 1'b0;
        run_frame("fff", FFF, 1'b0);

        // Mid-frame valid pulse and data change are ignored
        tick();
        handshake(8'h61);
        tx_valid = 1'b0;
        run_frame("dist", F61, 1'b1);
        tick();
        check("dist_noq", 32'(tx_busy), 32'd0);

        // Reset at clock 35 of a frame, then a clean 0xA5 frame
        handshake(8'h61);
        tx_valid = 1'b0;
        for (int i = 0; i < 34; i++) tick();
        check("pre_rst_txd", 32'(TxD), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(TxD), 32'd1);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_txd", 32'(TxD), 32'd1);
        handshake(8'hA5);
        tx_valid = 1'b0;
        run_frame("fa5", FA5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
